captura_chamadas: RTL and testbench

CAPTURA_CHAMADAS -- requirements
Module: captura_chamadas

---
 rtl/captura_chamadas.sv | 150 +++++++++++++++
 tb/tb_captura_chamadas.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_chamadas.sv
// rtl/captura_chamadas.sv - elevator call capture: button debounce, origin/destination FSM, call FIFO
module captura_chamadas #(
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int ANDAR_MAX       = 7,
  parameter int PROFUNDIDADE    = 4,
  parameter int TIMEOUT_CICLOS  = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            botao,
  input  logic [3:0]                      entrada,
  input  logic                            chamada_ready,
  output logic                            chamada_valid,
  output logic [3:0]                      origem,
  output logic [3:0]                      destino,
  output logic                            fila_cheia,
  output logic [$clog2(PROFUNDIDADE):0]   ocupacao,
  output logic                            erro,
  output logic [1:0]                      db_estado
);

  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [3:0]    AMAX    = 4'(ANDAR_MAX);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CICLOS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [AW:0]   CHEIO   = (AW + 1)'(PROFUNDIDADE);

  typedef enum logic [1:0] {
    ESPERA_ORIGEM  = 2'b00,
    ESPERA_DESTINO = 2'b01,
    GRAVA          = 2'b10
  } estado_t;

  logic          s1, s2;
  logic          db_nivel, db_prev;
  logic [DW-1:0] db_cnt;
  logic          press;

  estado_t       estado;
  logic [3:0]    orig_l, dest_l;
  logic [TW-1:0] tcnt;

  logic [7:0]    mem [PROFUNDIDADE];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cont;
  logic          push, pop;

  // Level only moves after the synchronized input disagrees for a full window.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      db_nivel <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      s1      <= botao;
      s2      <= s1;
      db_prev <= db_nivel;
      if (s2 != db_nivel) begin
        if (db_cnt == DB_LAST) begin
          db_nivel <= s2;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = db_nivel & ~db_prev;
  assign pop   = chamada_valid & chamada_ready;
  assign push  = (estado == GRAVA) & (~fila_cheia | pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= ESPERA_ORIGEM;
      orig_l <= '0;
      dest_l <= '0;
      tcnt   <= '0;
      erro   <= 1'b0;
    end else begin
      erro <= 1'b0;
      case (estado)
        ESPERA_ORIGEM: begin
          if (press) begin
            if (entrada <= AMAX) begin
              orig_l <= entrada;
              tcnt   <= '0;
              estado <= ESPERA_DESTINO;
            end else begin
              erro <= 1'b1;
            end
          end
        end
        ESPERA_DESTINO: begin
          if (press) begin
            if (entrada <= AMAX && entrada != orig_l) begin
              dest_l <= entrada;
              estado <= GRAVA;
            end else begin
              erro   <= 1'b1;
              orig_l <= '0;
              estado <= ESPERA_ORIGEM;
            end
          end else if (tcnt == TO_LAST) begin
            erro   <= 1'b1;
            orig_l <= '0;
            estado <= ESPERA_ORIGEM;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GRAVA: begin
          // Late presses here are dropped silently; wait for room in the queue.
          if (push) estado <= ESPERA_ORIGEM;
        end
        default: estado <= ESPERA_ORIGEM;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= {orig_l, dest_l};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cont <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cont <= cont + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  assign chamada_valid = (cont != '0);
  assign origem        = chamada_valid ? mem[rptr][7:4] : 4'd0;
  assign destino       = chamada_valid ? mem[rptr][3:0] : 4'd0;
  assign fila_cheia    = (cont == CHEIO);
  assign ocupacao      = cont;
  assign db_estado     = estado;

endmodule

// File: tb/tb_captura_chamadas.sv
// tb/tb_captura_chamadas.sv - directed, table-driven bench for captura_chamadas
module tb_captura_chamadas;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       botao = 1'b0;
  logic [3:0] entrada = 4'd0;
  logic       chamada_ready = 1'b0;
  logic       chamada_valid;
  logic [3:0] origem, destino;
  logic       fila_cheia;
  logic [2:0] ocupacao;
  logic       erro;
  logic [1:0] db_estado;

  int checks = 0;
  int failures = 0;
  int n_erro = 0;

  captura_chamadas dut (
    .clock(clock), .reset(reset), .botao(botao), .entrada(entrada),
    .chamada_ready(chamada_ready), .chamada_valid(chamada_valid),
    .origem(origem), .destino(destino), .fila_cheia(fila_cheia),
    .ocupacao(ocupacao), .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (erro === 1'b1) n_erro++;
  end

  typedef struct {
    int         n;
    logic [3:0] e1;
    logic [3:0] e2;
    int         errs;
    int         ocup;
    int         ho;
    int         hd;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic aperta(input logic [3:0] v);
    @(negedge clock);
    entrada = v;
    botao = 1'b1;
    ciclos(10);
    botao = 1'b0;
    ciclos(10);
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    botao = 1'b0;
    chamada_ready = 1'b0;
    ciclos(3);
    reset = 1'b0;
    ciclos(2);
  endtask

  task automatic chk_head(input string name, input int o, input int d);
    chk({name, "_origem"}, int'(origem), o);
    chk({name, "_destino"}, int'(destino), d);
  endtask

  initial begin
    int e0, n;
    vt[0] = '{n:1, e1:4'd9,  e2:4'd0, errs:1, ocup:0, ho:0, hd:0};
    vt[1] = '{n:2, e1:4'd3,  e2:4'd3, errs:1, ocup:0, ho:0, hd:0};
    vt[2] = '{n:2, e1:4'd2,  e2:4'd5, errs:0, ocup:1, ho:2, hd:5};
    vt[3] = '{n:1, e1:4'd15, e2:4'd0, errs:1, ocup:1, ho:2, hd:5};
    vt[4] = '{n:2, e1:4'd0,  e2:4'd7, errs:0, ocup:2, ho:2, hd:5};
    vt[5] = '{n:2, e1:4'd4,  e2:4'd8, errs:1, ocup:2, ho:2, hd:5};
    vt[6] = '{n:2, e1:4'd7,  e2:4'd6, errs:0, ocup:3, ho:2, hd:5};

    ciclos(3);
    chk("rst_valid", int'(chamada_valid), 0);
    chk("rst_origem", int'(origem), 0);
    chk("rst_destino", int'(destino), 0);
    chk("rst_cheia", int'(fila_cheia), 0);
    chk("rst_erro", int'(erro), 0);
    chk("rst_estado", int'(db_estado), 0);
    reset = 1'b0;
    ciclos(2);

    for (int i = 0; i < 7; i++) begin
      e0 = n_erro;
      aperta(vt[i].e1);
      if (vt[i].n == 2) aperta(vt[i].e2);
      chk($sformatf("vec%0d_erro", i), n_erro - e0, vt[i].errs);
      chk($sformatf("vec%0d_ocup", i), int'(ocupacao), vt[i].ocup);
      chk($sformatf("vec%0d_estado", i), int'(db_estado), 0);
      chk($sformatf("vec%0d_valid", i), int'(chamada_valid), vt[i].ocup != 0 ? 1 : 0);
      chk_head($sformatf("vec%0d", i), vt[i].ho, vt[i].hd);
    end

    // Bounce: ten single-cycle toggles, then held high
    do_reset;
    e0 = n_erro;
    entrada = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      botao = (i % 2 == 0);
    end
    @(negedge clock);
    botao = 1'b1;
    n = 0;
    while (db_estado != 2'b01 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("bounce_latency", n, 7);
    ciclos(20);
    chk("bounce_single_press", int'(db_estado), 1);
    chk("bounce_no_erro", n_erro - e0, 0);
    botao = 1'b0;
    ciclos(10);
    aperta(4'd6);
    chk("bounce_ocup", int'(ocupacao), 1);
    chk_head("bounce", 1, 6);

    // Button held through reset release
    @(negedge clock);
    reset = 1'b1;
    botao = 1'b1;
    entrada = 4'd3;
    ciclos(3);
    reset = 1'b0;
    e0 = n_erro;
    n = 0;
    while (db_estado != 2'b01 && n < 30) begin
      @(negedge clock);
      n++;
    end
    chk("held_reset_latency", n, 7);
    ciclos(20);
    botao = 1'b0;
    ciclos(10);
    chk("held_reset_one_press", int'(db_estado), 1);
    chk("held_reset_no_erro", n_erro - e0, 0);

    // Timeout in ESPERA_DESTINO
    do_reset;
    aperta(4'd2);
    aperta(4'd5);
    @(negedge clock);
    entrada = 4'd1;
    botao = 1'b1;
    n = 0;
    while (db_estado != 2'b01 && n < 30) begin
      @(negedge clock);
      n++;
    end
    botao = 1'b0;
    e0 = n_erro;
    n = 0;
    while (db_estado == 2'b01 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_erro", int'(erro), 1);
    chk("timeout_estado", int'(db_estado), 0);
    chk("timeout_ocup", int'(ocupacao), 1);
    chk_head("timeout", 2, 5);
    ciclos(12);
    chk("timeout_erro_count", n_erro - e0, 1);

    // Full FIFO with a pending fifth pair
    do_reset;
    aperta(4'd1); aperta(4'd2);
    aperta(4'd3); aperta(4'd4);
    aperta(4'd5); aperta(4'd6);
    aperta(4'd7); aperta(4'd0);
    chk("full_cheia", int'(fila_cheia), 1);
    chk("full_ocup", int'(ocupacao), 4);
    aperta(4'd2);
    aperta(4'd3);
    chk("full_grava_hold", int'(db_estado), 2);
    chk_head("full_head", 1, 2);
    @(negedge clock);
    chamada_ready = 1'b1;
    @(negedge clock);
    chamada_ready = 1'b0;
    chk("full_pushpop_ocup", int'(ocupacao), 4);
    chk("full_pushpop_estado", int'(db_estado), 0);
    chk("full_pushpop_cheia", int'(fila_cheia), 1);
    @(negedge clock);
    chamada_ready = 1'b1;
    chk_head("drain0", 3, 4);
    @(negedge clock);
    chk_head("drain1", 5, 6);
    @(negedge clock);
    chk_head("drain2", 7, 0);
    @(negedge clock);
    chk_head("drain3", 2, 3);
    @(negedge clock);
    chk("drain_empty_valid", int'(chamada_valid), 0);
    chk_head("drain_empty", 0, 0);
    @(negedge clock);
    chk("ready_while_empty_ocup", int'(ocupacao), 0);
    chamada_ready = 1'b0;

    // Reset with queued pairs and a partial call
    do_reset;
    aperta(4'd1); aperta(4'd2);
    aperta(4'd3); aperta(4'd4);
    aperta(4'd5);
    chk("midrst_pre_estado", int'(db_estado), 1);
    chk("midrst_pre_ocup", int'(ocupacao), 2);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_valid", int'(chamada_valid), 0);
    chk("midrst_ocup", int'(ocupacao), 0);
    chk("midrst_cheia", int'(fila_cheia), 0);
    chk("midrst_erro", int'(erro), 0);
    chk("midrst_estado", int'(db_estado), 0);
    chk_head("midrst", 0, 0);
    reset = 1'b0;
    ciclos(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
